// File: rtl/keymgr_pkg.sv
// keymgr_pkg: shared types and constants for the key manager sideload path.
// Provides the sideload key request structure seen by every consumer, the
// share/entropy geometry, the receiver state encoding shared between engines
// and assertions, and a helper that fills a key word from one entropy word.
package keymgr_pkg;

    localparam int unsigned KeyWidth  = 256;
    localparam int unsigned Shares    = 2;
    localparam int unsigned RandWidth = 32;

    typedef struct packed {
        logic                valid;
        logic [KeyWidth-1:0] key_share0;
        logic [KeyWidth-1:0] key_share1;
    } hw_key_req_t;

    // One-hot encoding: any other value held by the state register is illegal.
    typedef enum logic [3:0] {
        SideloadRxIdle   = 4'b0001,
        SideloadRxWait   = 4'b0010,
        SideloadRxLoaded = 4'b0100,
        SideloadRxError  = 4'b1000
    } sideload_rx_state_e;

    // Replicates one entropy word across a whole key share for scrubbing.
    function automatic logic [KeyWidth-1:0] wipe_fill(input logic [RandWidth-1:0] ent);
        return {(KeyWidth/RandWidth){ent}};
    endfunction

endpackage

// File: rtl/sideload_key_rx_cnt.sv
// sideload_key_rx_cnt: saturating wait counter for the sideload receiver.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (counter -> 0)
//   clr_i   synchronous clear to 0 (priority over enable)
//   en_i    count enable; the counter stops at TimeoutCycles-1 and never wraps
//   tc_o    terminal count: counter equals TimeoutCycles-1
module sideload_key_rx_cnt #(
    parameter  int unsigned TimeoutCycles = 1024,
    localparam int unsigned CntWidth      = $clog2(TimeoutCycles)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CntWidth-1:0] TcVal = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] cnt_reg;

    assign tc_o = (cnt_reg == TcVal);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else if (clr_i) begin
            cnt_reg <= '0;
        end else if (en_i && !tc_o) begin
            cnt_reg <= cnt_reg + CntWidth'(1);
        end
    end

endmodule

// File: rtl/sideload_key_rx.sv
// sideload_key_rx: consumer endpoint of the key manager sideload interface.
// On an engine request it waits for a valid sideload key, captures both
// shares and holds them until the engine is done. The captured key is
// scrubbed with entropy when use ends or when the key manager withdraws
// validity; withdrawal and wait timeout raise a sticky error.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   key_i           sideload key (valid + two shares) from the key manager
//   entropy_i       scrub entropy, one word per share
//   req_i           engine requests a key (level, looked at in Idle only)
//   done_i          engine finished with the key (looked at in Loaded only)
//   clr_err_i       pulse clearing the sticky error
//   ack_o           key captured and stable on key_share*_o
//   key_share0_o/1  captured shares, straight from the key registers
//   busy_o          waiting for or holding a key
//   err_o           sticky error
module sideload_key_rx
    import keymgr_pkg::*;
#(
    parameter  int unsigned TimeoutCycles = 1024,
    localparam int unsigned CntWidth      = $clog2(TimeoutCycles)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  hw_key_req_t                         key_i,
    input  logic [Shares-1:0][RandWidth-1:0]    entropy_i,
    input  logic                                req_i,
    input  logic                                done_i,
    input  logic                                clr_err_i,
    output logic                                ack_o,
    output logic [KeyWidth-1:0]                 key_share0_o,
    output logic [KeyWidth-1:0]                 key_share1_o,
    output logic                                busy_o,
    output logic                                err_o
);

    sideload_rx_state_e state_reg, state_next;

    logic [Shares-1:0][KeyWidth-1:0] key_reg, key_next;
    logic load_en, wipe_en;
    logic cnt_clr, cnt_en, cnt_tc;

    // The counter only runs while waiting; it sits at zero everywhere else so
    // every Wait entry starts a fresh timeout window.
    assign cnt_en  = (state_reg == SideloadRxWait);
    assign cnt_clr = (state_reg != SideloadRxWait);

    sideload_key_rx_cnt #(
        .TimeoutCycles (TimeoutCycles)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_next = state_reg;
        load_en    = 1'b0;
        wipe_en    = 1'b0;
        case (state_reg)
            SideloadRxIdle: begin
                if (req_i) begin
                    state_next = SideloadRxWait;
                end
            end
            SideloadRxWait: begin
                // A key arriving on the last allowed cycle still wins over timeout.
                if (key_i.valid) begin
                    load_en    = 1'b1;
                    state_next = SideloadRxLoaded;
                end else if (cnt_tc) begin
                    state_next = SideloadRxError;
                end
            end
            SideloadRxLoaded: begin
                // done_i first: a valid drop in the same cycle is not an error.
                if (done_i) begin
                    wipe_en    = 1'b1;
                    state_next = SideloadRxIdle;
                end else if (!key_i.valid) begin
                    wipe_en    = 1'b1;
                    state_next = SideloadRxError;
                end
            end
            SideloadRxError: begin
                if (clr_err_i) begin
                    state_next = SideloadRxIdle;
                end
            end
            default: begin
                state_next = SideloadRxError;
            end
        endcase
    end

    always_comb begin
        key_next = key_reg;
        if (load_en) begin
            key_next[0] = key_i.key_share0;
            key_next[1] = key_i.key_share1;
        end else if (wipe_en) begin
            for (int i = 0; i < Shares; i++) begin
                key_next[i] = wipe_fill(entropy_i[i]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= SideloadRxIdle;
            key_reg   <= '0;
        end else begin
            state_reg <= state_next;
            key_reg   <= key_next;
        end
    end

    assign ack_o        = (state_reg == SideloadRxLoaded);
    assign busy_o       = (state_reg == SideloadRxWait) || (state_reg == SideloadRxLoaded);
    assign err_o        = (state_reg == SideloadRxError);
    assign key_share0_o = key_reg[0];
    assign key_share1_o = key_reg[1];

    // Key must not move while the engine keeps using it.
    a_key_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_reg == SideloadRxLoaded && state_next == SideloadRxLoaded) |=> $stable(key_reg));

    a_err_ack_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(err_o && ack_o));

    a_state_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_reg inside {SideloadRxIdle, SideloadRxWait, SideloadRxLoaded, SideloadRxError});

endmodule

// File: tb/tb_sideload_key_rx.sv
// tb_sideload_key_rx: directed self-checking bench for sideload_key_rx with a
// 16-cycle timeout. Inputs change 1 time unit after a rising edge and outputs
// are checked 1 time unit after the edge that should have updated them.
module tb_sideload_key_rx;
    import keymgr_pkg::*;

    localparam int unsigned Tmo = 16;

    logic                             clk_i = 1'b0;
    logic                             rst_ni;
    hw_key_req_t                      key_i;
    logic [Shares-1:0][RandWidth-1:0] entropy_i;
    logic                             req_i, done_i, clr_err_i;
    logic                             ack_o, busy_o, err_o;
    logic [KeyWidth-1:0]              key_share0_o, key_share1_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [KeyWidth-1:0] KeyA0 = {32{8'hA5}};
    localparam logic [KeyWidth-1:0] KeyA1 = {32{8'h5A}};
    localparam logic [KeyWidth-1:0] KeyB0 = {8{32'h1111_2222}};
    localparam logic [KeyWidth-1:0] KeyB1 = {8{32'h3333_4444}};
    localparam logic [KeyWidth-1:0] WipeE0 = {8{32'hDEAD_BEEF}};
    localparam logic [KeyWidth-1:0] WipeE1 = {8{32'h0123_4567}};
    localparam logic [KeyWidth-1:0] WipeF0 = {8{32'hCAFE_F00D}};
    localparam logic [KeyWidth-1:0] WipeF1 = {8{32'h8765_4321}};

    always #5 clk_i = ~clk_i;

    sideload_key_rx #(
        .TimeoutCycles (Tmo)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .key_i        (key_i),
        .entropy_i    (entropy_i),
        .req_i        (req_i),
        .done_i       (done_i),
        .clr_err_i    (clr_err_i),
        .ack_o        (ack_o),
        .key_share0_o (key_share0_o),
        .key_share1_o (key_share1_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    task automatic check(input string tag, input logic [KeyWidth-1:0] act,
                         input logic [KeyWidth-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic a, input logic b, input logic e);
        check({tag, ".ack"},  KeyWidth'(ack_o),  KeyWidth'(a));
        check({tag, ".busy"}, KeyWidth'(busy_o), KeyWidth'(b));
        check({tag, ".err"},  KeyWidth'(err_o),  KeyWidth'(e));
    endtask

    // Request with the key already valid: Wait after one edge, Loaded after two.
    task automatic load_key(input string tag, input logic [KeyWidth-1:0] s0,
                            input logic [KeyWidth-1:0] s1);
        key_i.valid      = 1'b1;
        key_i.key_share0 = s0;
        key_i.key_share1 = s1;
        req_i = 1'b1;
        tick(1);
        req_i = 1'b0;
        check_flags({tag, ".wait"}, 1'b0, 1'b1, 1'b0);
        tick(1);
        check_flags({tag, ".loaded"}, 1'b1, 1'b1, 1'b0);
        check({tag, ".share0"}, key_share0_o, s0);
        check({tag, ".share1"}, key_share1_o, s1);
    endtask

    initial begin
        rst_ni = 1'b0;
        key_i  = '0;
        entropy_i = '0;
        req_i = 1'b0; done_i = 1'b0; clr_err_i = 1'b0;

        // Reset values
        tick(3);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        check("rst.share0", key_share0_o, '0);
        check("rst.share1", key_share1_o, '0);
        rst_ni = 1'b1;
        tick(2);
        $display("[TB] reset: ack=%0b busy=%0b err=%0b", ack_o, busy_o, err_o);

        // Normal load, share change while loaded, done with scrub
        load_key("norm", KeyA0, KeyA1);
        key_i.key_share0 = KeyB0;
        key_i.key_share1 = KeyB1;
        tick(3);
        check("norm.hold0", key_share0_o, KeyA0);
        check("norm.hold1", key_share1_o, KeyA1);
        entropy_i[0] = 32'hDEAD_BEEF;
        entropy_i[1] = 32'h0123_4567;
        done_i = 1'b1;
        tick(1);
        done_i = 1'b0;
        check_flags("norm.done", 1'b0, 1'b0, 1'b0);
        check("norm.wipe0", key_share0_o, WipeE0);
        check("norm.wipe1", key_share1_o, WipeE1);
        $display("[TB] normal: load A5/5A, done -> wiped %h", key_share0_o[31:0]);

        // Late key, arriving after 10 cycles in Wait
        key_i.valid = 1'b0;
        req_i = 1'b1;
        tick(1);
        req_i = 1'b0;
        tick(9);
        check_flags("late.wait", 1'b0, 1'b1, 1'b0);
        key_i.valid = 1'b1;
        tick(1);
        check_flags("late.ack", 1'b1, 1'b1, 1'b0);
        check("late.share0", key_share0_o, KeyB0);
        done_i = 1'b1;
        tick(1);
        done_i = 1'b0;
        $display("[TB] late key: ack after 10 wait cycles");

        // Key arriving on the very last Wait cycle still loads
        key_i.valid = 1'b0;
        req_i = 1'b1;
        tick(1);
        req_i = 1'b0;
        tick(Tmo - 1);
        check_flags("edge.last", 1'b0, 1'b1, 1'b0);
        key_i.valid = 1'b1;
        tick(1);
        check_flags("edge.ack", 1'b1, 1'b1, 1'b0);
        done_i = 1'b1;
        tick(1);
        done_i = 1'b0;
        $display("[TB] boundary: key on last wait cycle accepted");

        // Timeout, request ignored in Error, clear, then new request accepted
        key_i.valid = 1'b0;
        req_i = 1'b1;
        tick(1);
        req_i = 1'b0;
        tick(Tmo - 1);
        check_flags("tmo.pre", 1'b0, 1'b1, 1'b0);
        tick(1);
        check_flags("tmo.err", 1'b0, 1'b0, 1'b1);
        req_i = 1'b1;
        tick(2);
        check_flags("tmo.reqign", 1'b0, 1'b0, 1'b1);
        req_i = 1'b0;
        clr_err_i = 1'b1;
        tick(1);
        clr_err_i = 1'b0;
        check_flags("tmo.clr", 1'b0, 1'b0, 1'b0);
        $display("[TB] timeout: err after %0d wait cycles, cleared", Tmo);

        // Withdrawal while loaded
        load_key("wdr", KeyA0, KeyB1);
        entropy_i[0] = 32'hCAFE_F00D;
        entropy_i[1] = 32'h8765_4321;
        key_i.valid = 1'b0;
        tick(1);
        check_flags("wdr.err", 1'b0, 1'b0, 1'b1);
        check("wdr.wipe0", key_share0_o, WipeF0);
        check("wdr.wipe1", key_share1_o, WipeF1);
        key_i.valid = 1'b1;
        req_i = 1'b1;
        tick(2);
        check_flags("wdr.reqign", 1'b0, 1'b0, 1'b1);
        check("wdr.noreload", key_share0_o, WipeF0);
        req_i = 1'b0;
        clr_err_i = 1'b1;
        tick(1);
        clr_err_i = 1'b0;
        check_flags("wdr.clr", 1'b0, 1'b0, 1'b0);
        $display("[TB] withdrawal: err with wiped key, cleared");

        // done_i and valid drop together: done wins, no error
        load_key("sim", KeyB0, KeyA1);
        entropy_i[0] = 32'hDEAD_BEEF;
        entropy_i[1] = 32'h0123_4567;
        done_i = 1'b1;
        key_i.valid = 1'b0;
        tick(1);
        done_i = 1'b0;
        check_flags("sim.idle", 1'b0, 1'b0, 1'b0);
        check("sim.wipe1", key_share1_o, WipeE1);
        $display("[TB] simultaneous done/drop: idle, no error");

        // Asynchronous reset while loaded
        load_key("rst2", KeyA0, KeyA1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_flags("rst2.async", 1'b0, 1'b0, 1'b0);
        check("rst2.share0", key_share0_o, '0);
        check("rst2.share1", key_share1_o, '0);
        tick(1);
        rst_ni = 1'b1;
        tick(1);
        check_flags("rst2.idle", 1'b0, 1'b0, 1'b0);
        req_i = 1'b1;
        tick(1);
        req_i = 1'b0;
        check_flags("rst2.req", 1'b0, 1'b1, 1'b0);
        $display("[TB] reset in loaded: outputs cleared, idle after release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
